// File: rtl/sram_like_slave_if.sv
// rtl/sram_like_slave_if.sv - sram-like request/response bus between initiator and memory responder
interface sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - fixed-latency in-order on-chip memory responder for the sram-like port
module sram_like_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_like_slave_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [3:0]       AGE_MAX = 4'(LATENCY);
    localparam logic [3:0]       AGE_DUE = 4'(LATENCY - 1);

    logic [31:0]      mem [2**ADDR_W];
    logic [31:0]      entry_data [DEPTH];
    logic [3:0]       age [DEPTH];
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [ADDR_W-1:0] index;
    logic [3:0]       byte_en;
    logic             misaligned;
    logic             push;
    logic             pop;

    assign index       = bus.addr[ADDR_W+1:2];
    assign bus.addr_ok = (count != FULL);
    assign push        = bus.req && bus.addr_ok;
    assign pop         = (count != '0) && (age[head] == AGE_DUE);
    assign bus.data_ok = pop;
    assign bus.rdata   = pop ? entry_data[head] : 32'h0;

    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        case (bus.size)
            2'd0: byte_en = 4'b0001 << bus.addr[1:0];
            2'd1: begin
                misaligned = bus.addr[0];
                byte_en    = bus.addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                misaligned = (bus.addr[1:0] != 2'b00);
                byte_en    = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Memory is deliberately left out of reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (push && bus.wr && !misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[index][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is snapshotted at acceptance, so later writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_data[tail] <= bus.wr ? 32'h0 : mem[index];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + 4'd1;
                end
            end
            if (push) begin
                age[tail] <= '0;
                tail      <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
